// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver with one word of buffering (shift register + output register).
// Define SIPO_PARITY_CHECK_EN to expect a trailing even-parity bit per word and report parity_err.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_PARITY_CHECK_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  // FULL means a complete word is parked in shreg waiting for the output register
  typedef enum logic {SHIFT, FULL} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] shreg, shreg_n, out_n, shifted, assembled;
  logic             out_valid_n, overrun_n;
  logic             accept, drain, last;
`ifdef SIPO_PARITY_CHECK_EN
  logic             par_q, par_n, perr_q, perr_n, data_bit;
`endif

  assign in_ready = (state == SHIFT);
`ifdef SIPO_PARITY_CHECK_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SHIFT;
      count     <= '0;
      shreg     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      count     <= count_n;
      shreg     <= shreg_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      overrun   <= overrun_n;
`ifdef SIPO_PARITY_CHECK_EN
      par_q     <= par_n;
      perr_q    <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    shreg_n     = shreg;
    out_n       = out;
    out_valid_n = out_valid;
    overrun_n   = overrun;
`ifdef SIPO_PARITY_CHECK_EN
    par_n       = par_q;
    perr_n      = perr_q;
    data_bit    = (count < CW'(WIDTH));
`endif

    accept = sin_valid && in_ready && !flush;
    drain  = out_valid && out_ready;
    last   = (count == LAST);

    if (MSB_FIRST) shifted = {shreg[WIDTH-2:0], sin_data};
    else           shifted = {sin_data, shreg[WIDTH-1:1]};

`ifdef SIPO_PARITY_CHECK_EN
    // the parity bit is checked but never shifted into the data word
    assembled = data_bit ? shifted : shreg;
`else
    assembled = shifted;
`endif

    if (drain) out_valid_n = 1'b0;
    if (sin_valid && !in_ready) overrun_n = 1'b1;

    if (flush) begin
      state_n = SHIFT;
      count_n = '0;
      shreg_n = '0;
`ifdef SIPO_PARITY_CHECK_EN
      par_n   = 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (accept) begin
            shreg_n = assembled;
            if (!last) begin
              count_n = count + 1'b1;
            end else if (!out_valid || out_ready) begin
              // word goes straight to the output register, possibly replacing one being consumed
              out_n       = assembled;
              out_valid_n = 1'b1;
              count_n     = '0;
`ifdef SIPO_PARITY_CHECK_EN
              perr_n      = (^assembled) ^ sin_data;
`endif
            end else begin
              state_n = FULL;
              count_n = '0;
`ifdef SIPO_PARITY_CHECK_EN
              par_n   = sin_data;
`endif
            end
          end
        end
        FULL: begin
          if (drain) begin
            out_n       = shreg;
            out_valid_n = 1'b1;
            state_n     = SHIFT;
            count_n     = '0;
`ifdef SIPO_PARITY_CHECK_EN
            perr_n      = (^shreg) ^ par_q;
`endif
          end
        end
        default: state_n = SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (MSB-first and LSB-first instances driven in lockstep).
// Exercises the SIPO_PARITY_CHECK_EN build with its own parity-word sequences when that macro is defined.
module tb_sipo_deserializer;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0, flush = 1'b0, sin_valid = 1'b0, sin_data = 1'b0, out_ready = 1'b0;
  logic             in_ready, out_valid, overrun, parity_err;
  logic             in_ready2, out_valid2, overrun2, parity_err2;
  logic [WIDTH-1:0] out, out2;

  int checks = 0;
  int errors = 0;

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .sin_valid(sin_valid), .sin_data(sin_data),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .parity_err(parity_err)
  );

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .flush(flush), .sin_valid(sin_valid), .sin_data(sin_data),
    .in_ready(in_ready2), .out(out2), .out_valid(out_valid2), .out_ready(out_ready),
    .overrun(overrun2), .parity_err(parity_err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       fl;
    logic       sv;
    logic       sd;
    logic       ordy;
    logic [3:0] e_out;
    logic [3:0] e_out2;
    logic       e_ov;
    logic       e_ir;
    logic       e_orun;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic sv, logic sd, logic ordy,
                              logic [3:0] eo, logic [3:0] eo2, logic eov, logic eir, logic eorun);
    vec_t t;
    t.rst_n = r; t.fl = f; t.sv = sv; t.sd = sd; t.ordy = ordy;
    t.e_out = eo; t.e_out2 = eo2; t.e_ov = eov; t.e_ir = eir; t.e_orun = eorun;
    return t;
  endfunction

  function automatic logic [3:0] rev4(logic [3:0] x);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = x[3-i];
    return r;
  endfunction

  // inputs are changed at a falling edge and outputs are read at the next falling edge
  task automatic applyStimulus(input logic r, input logic f, input logic sv, input logic sd, input logic ordy);
    reset = r; flush = f; sin_valid = sv; sin_data = sd; out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef SIPO_PARITY_CHECK_EN
  task automatic sendParityWord(input logic [3:0] data, input logic pbit, input logic ordy);
    for (int i = 3; i >= 0; i--) applyStimulus(1'b1, 1'b0, 1'b1, data[i], ordy);
    applyStimulus(1'b1, 1'b0, 1'b1, pbit, ordy);
  endtask
`endif

  initial begin
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_out", out, 4'b0000);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_parity_err", parity_err, 1'b0);

`ifndef SIPO_PARITY_CHECK_EN
    // basic word, then drain
    tbl.push_back(mk(1,0,1,1,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b1011, 4'b1101, 1,1,0));
    tbl.push_back(mk(1,0,0,0,1, 4'b1011, 4'b1101, 0,1,0));
    // backpressure: two words, second parks in FULL
    tbl.push_back(mk(1,0,1,1,0, 4'b1011, 4'b1101, 0,1,0));
    tbl.push_back(mk(1,0,1,0,0, 4'b1011, 4'b1101, 0,1,0));
    tbl.push_back(mk(1,0,1,1,0, 4'b1011, 4'b1101, 0,1,0));
    tbl.push_back(mk(1,0,1,1,0, 4'b1011, 4'b1101, 1,1,0));
    tbl.push_back(mk(1,0,1,0,0, 4'b1011, 4'b1101, 1,1,0));
    tbl.push_back(mk(1,0,1,1,0, 4'b1011, 4'b1101, 1,1,0));
    tbl.push_back(mk(1,0,1,1,0, 4'b1011, 4'b1101, 1,1,0));
    tbl.push_back(mk(1,0,1,0,0, 4'b1011, 4'b1101, 1,0,0));
    // overrun while FULL, then release and drain
    tbl.push_back(mk(1,0,1,1,0, 4'b1011, 4'b1101, 1,0,1));
    tbl.push_back(mk(1,0,0,0,1, 4'b0110, 4'b0110, 1,1,1));
    tbl.push_back(mk(1,0,0,0,1, 4'b0110, 4'b0110, 0,1,1));
    tbl.push_back(mk(0,0,0,0,0, 4'b0000, 4'b0000, 0,1,0));
    // flush mid-word
    tbl.push_back(mk(1,0,1,1,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,1,1,0,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b0111, 4'b1110, 1,1,0));
    tbl.push_back(mk(1,0,0,0,1, 4'b0111, 4'b1110, 0,1,0));
    // reset mid-word, then a fresh word proves the count restarted
    tbl.push_back(mk(1,0,1,1,1, 4'b0111, 4'b1110, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b0111, 4'b1110, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b0111, 4'b1110, 0,1,0));
    tbl.push_back(mk(0,0,0,0,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'b0000, 4'b0000, 0,1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'b1000, 4'b0001, 1,1,0));
    // completion coinciding with a consume of the previous word
    tbl.push_back(mk(1,0,1,1,0, 4'b1000, 4'b0001, 1,1,0));
    tbl.push_back(mk(1,0,1,1,0, 4'b1000, 4'b0001, 1,1,0));
    tbl.push_back(mk(1,0,1,0,0, 4'b1000, 4'b0001, 1,1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'b1100, 4'b0011, 1,1,0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst_n, tbl[i].fl, tbl[i].sv, tbl[i].sd, tbl[i].ordy);
      checkOutput($sformatf("row%0d_out", i), out, tbl[i].e_out);
      checkOutput($sformatf("row%0d_out_lsb", i), out2, tbl[i].e_out2);
      checkOutput($sformatf("row%0d_out_valid", i), out_valid, tbl[i].e_ov);
      checkOutput($sformatf("row%0d_in_ready", i), in_ready, tbl[i].e_ir);
      checkOutput($sformatf("row%0d_overrun", i), overrun, tbl[i].e_orun);
      checkOutput($sformatf("row%0d_parity_err", i), parity_err, 1'b0);
    end

    // flush while FULL discards the parked word while a simultaneous drain proceeds
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("full_in_ready", in_ready, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_drain_out_valid", out_valid, 1'b0);
    checkOutput("flush_drain_out", out, 4'b1100);
    checkOutput("flush_drain_in_ready", in_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("after_flush_partial_valid", out_valid, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("after_flush_out", out, 4'b0001);
    checkOutput("after_flush_out_lsb", out2, rev4(4'b0001));
    checkOutput("after_flush_out_valid", out_valid, 1'b1);
    checkOutput("after_flush_overrun", overrun, 1'b0);
`else
    // parity build: each word is 4 data bits plus an even-parity bit
    sendParityWord(4'b1011, 1'b0, 1'b1);
    checkOutput("par_a_out", out, 4'b1011);
    checkOutput("par_a_out_lsb", out2, rev4(4'b1011));
    checkOutput("par_a_valid", out_valid, 1'b1);
    checkOutput("par_a_err", parity_err, 1'b1);
    sendParityWord(4'b1011, 1'b1, 1'b1);
    checkOutput("par_b_out", out, 4'b1011);
    checkOutput("par_b_err", parity_err, 1'b0);
    sendParityWord(4'b0110, 1'b1, 1'b1);
    checkOutput("par_c_out", out, 4'b0110);
    checkOutput("par_c_err", parity_err, 1'b1);
    sendParityWord(4'b1110, 1'b0, 1'b0);
    checkOutput("par_park_in_ready", in_ready, 1'b0);
    checkOutput("par_park_out", out, 4'b0110);
    checkOutput("par_park_err", parity_err, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("par_release_out", out, 4'b1110);
    checkOutput("par_release_valid", out_valid, 1'b1);
    checkOutput("par_release_err", parity_err, 1'b1);
    checkOutput("par_release_in_ready", in_ready, 1'b1);
    sendParityWord(4'b0000, 1'b0, 1'b1);
    checkOutput("par_d_out", out, 4'b0000);
    checkOutput("par_d_err", parity_err, 1'b0);
    sendParityWord(4'b1110, 1'b1, 1'b1);
    checkOutput("par_e_out", out, 4'b1110);
    checkOutput("par_e_err", parity_err, 1'b0);
    checkOutput("par_overrun", overrun, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver; the far-end counterpart of the team's parallel-in serial-out shifter.
- Collects WIDTH serial bits qualified by sin_valid and presents the assembled word on a parallel output register.
- Uses a valid/ready handshake with one word of buffering: shift register plus output register.
- Sits between a serial link input and the parallel datapath that consumes 4-bit words.

Parameters:
- WIDTH, 4, number of data bits per word (minimum 2).
- MSB_FIRST, 1, 1 = first received bit lands in out[WIDTH-1]; 0 = first received bit lands in out[0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- flush  input  1  synchronous clear of the partially assembled word; does not affect the output register.
- sin_valid  input  1  sin_data is a valid bit this cycle.
- sin_data  input  1  serial data bit.
- in_ready  output  1  block can accept a bit this cycle.
- out  output  WIDTH  assembled parallel word.
- out_valid  output  1  out holds an unconsumed word.
- out_ready  input  1  consumer takes out this cycle when out_valid=1.
- overrun  output  1  sticky flag: a bit arrived while in_ready=0.
- parity_err  output  1  see Optional Feature.

Behaviour:
- Reset (reset=0 at a clk edge) clears everything: shreg=0, count=0, out=0, out_valid=0, overrun=0, parity_err=0. Hence in_ready=1 on the first cycle after reset. Reset has priority over all other inputs and aborts any partial word.
- State is defined by count (0..WIDTH) and out_valid:
  - SHIFT: count<WIDTH.
  - FULL: count==WIDTH, a complete word is parked in shreg.
- in_ready = (count != WIDTH). It is combinational from registers only.
- A bit is accepted when sin_valid && in_ready:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin_data}.
  - MSB_FIRST=0: shreg <= {sin_data, shreg[WIDTH-1:1]}.
  - count increments on each accepted bit.
- Completion: the accepted bit with count==WIDTH-1 completes a word.
  - If out_valid==0, or out_valid && out_ready in the same cycle: out <= assembled word, out_valid <= 1, count <= 0. out is visible the cycle after the last bit is accepted, so latency is 1.
  - Otherwise: count <= WIDTH and the block enters FULL.
- FULL: when out_valid && out_ready, out <= shreg, out_valid stays 1, count <= 0. in_ready rises the next cycle.
- Drain: out_valid && out_ready with no word transferring gives out_valid <= 0. out keeps its last value.
- Overrun: sin_valid && !in_ready discards the bit and sets overrun <= 1. overrun clears only on reset.
- flush=1: count <= 0 and shreg <= 0, including from FULL; the parked word is lost. Bits offered in a flush cycle are ignored. out and out_valid are unaffected. A flush coinciding with a drain lets the drain proceed.
- The counter never wraps past WIDTH, and no data is ever silently overwritten.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Each word is WIDTH+1 bits; the final bit is an even-parity bit over the data bits and is not stored in shreg data.
  - count range is 0..WIDTH+1; completion occurs on the parity bit.
  - parity_err is registered alongside out and equals (^data) ^ parity_bit. It is valid only while out_valid=1.
- Not defined: words are WIDTH bits and parity_err is tied to 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with sin_valid=1 -> out=4'b0000, out_valid=0, in_ready=1, overrun=0.
- Basic: out_ready=1, send bits 1,0,1,1 on consecutive cycles -> out=4'b1011 and out_valid=1 for exactly one cycle, starting the cycle after bit 4.
- Backpressure: out_ready=0, send 1011 then 0110 -> out=1011, in_ready=0 after the 8th bit. Then raise out_ready for one cycle -> out=0110 next cycle, in_ready=1.
- Overrun: in FULL, drive sin_valid=1, sin_data=1 -> overrun=1 and stays 1, shreg and out unchanged. Reset -> overrun=0.
- Flush/reset mid-word:
  - Send 1,1, then flush=1, then 0,1,1,1 -> out=0111.
  - Send 3 bits, then reset=0 -> count=0 and the output is cleared.
- Variants:
  - MSB_FIRST=0, send 1,0,0,0 -> out=0001.
  - With SIPO_PARITY_CHECK_EN, send 1,0,1,1,0 -> out=1011, parity_err=1.
  - With SIPO_PARITY_CHECK_EN, send 1,0,1,1,1 -> parity_err=0.
